// File: rtl/mem_wb_stage.sv
// =============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register with load alignment and a wait state
//               for slow data memory. Optional macro WB_FWD_EN adds
//               writeback-to-decode forwarding hit outputs.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_wb_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        MEM_VALID,
    input  logic        MEM_REGWRITE,
    input  logic [4:0]  MEM_RD,
    input  logic [1:0]  MEM_WBSEL,
    input  logic [2:0]  MEM_FUNCT3,
    input  logic [31:0] MEM_ALU_RESULT,
    input  logic [31:0] MEM_PC4,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_BUSY,
`ifdef WB_FWD_EN
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    output logic        FWD1_HIT,
    output logic        FWD2_HIT,
`endif
    output logic [31:0] WB_DATA,
    output logic [4:0]  WB_RD,
    output logic        WB_WRITE,
    output logic        WB_HIT,
    output logic        WB_BUSY
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_MEM = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic        valid_q;
    logic        regwrite_q;
    logic [4:0]  rd_q;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    logic [31:0] data_q;
    logic [31:0] capture_data;
    logic        capture;
    logic        load_stalls;

    function automatic logic [31:0] align_load(
        input logic [31:0] word,
        input logic [1:0]  offset,
        input logic [2:0]  funct3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b100:  align_load = {24'd0, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b101:  align_load = {16'd0, h};
            default: align_load = word;
        endcase
    endfunction

    assign capture     = (state == S_IDLE) && !FLUSH && !STALL;
    assign load_stalls = MEM_VALID && (MEM_WBSEL == 2'b01) && DMEM_BUSY;

    always_comb begin
        capture_data = MEM_ALU_RESULT;
        case (MEM_WBSEL)
            2'b01:   capture_data = align_load(DMEM_RDATA, MEM_ALU_RESULT[1:0], MEM_FUNCT3);
            2'b10:   capture_data = MEM_PC4;
            default: capture_data = MEM_ALU_RESULT;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (FLUSH) begin
            state_next = S_IDLE;
        end else if (state == S_IDLE) begin
            if (!STALL && load_stalls) begin
                state_next = S_WAIT_MEM;
            end
        end else begin
            if (!DMEM_BUSY) begin
                state_next = S_IDLE;
            end
        end
    end

    // Output logic
    always_comb begin
        WB_HIT   = valid_q && (state == S_IDLE);
        WB_BUSY  = (state == S_WAIT_MEM);
        WB_WRITE = WB_HIT && regwrite_q && (rd_q != 5'd0);
    end

    // Stage datapath; a stalled load keeps its byte offset and funct3 for the late data
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            offset_q   <= 2'd0;
            funct3_q   <= 3'd0;
            data_q     <= 32'd0;
        end else if (FLUSH) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q    <= MEM_VALID;
            regwrite_q <= MEM_REGWRITE;
            rd_q       <= MEM_RD;
            offset_q   <= MEM_ALU_RESULT[1:0];
            funct3_q   <= MEM_FUNCT3;
            if (!load_stalls) begin
                data_q <= capture_data;
            end
        end else if ((state == S_WAIT_MEM) && !DMEM_BUSY) begin
            data_q <= align_load(DMEM_RDATA, offset_q, funct3_q);
        end
    end

    assign WB_DATA = data_q;
    assign WB_RD   = rd_q;

`ifdef WB_FWD_EN
    assign FWD1_HIT = WB_WRITE && (ID_RS1 == rd_q);
    assign FWD2_HIT = WB_WRITE && (ID_RS2 == rd_q);
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// =============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage: directed scenarios with
//               literal expectations plus randomized traffic against a model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RESET, STALL, FLUSH, MEM_VALID, MEM_REGWRITE, DMEM_BUSY;
    logic [4:0]  MEM_RD;
    logic [1:0]  MEM_WBSEL;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ALU_RESULT, MEM_PC4, DMEM_RDATA;
    logic [31:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        WB_WRITE, WB_HIT, WB_BUSY;
`ifdef WB_FWD_EN
    logic [4:0]  ID_RS1, ID_RS2;
    logic        FWD1_HIT, FWD2_HIT;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: what the stage holds, and whether a load is still outstanding
    bit          m_valid, m_rw, m_pending;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [1:0]  m_off;
    logic [2:0]  m_f3;

    mem_wb_stage dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .MEM_VALID(MEM_VALID), .MEM_REGWRITE(MEM_REGWRITE), .MEM_RD(MEM_RD),
        .MEM_WBSEL(MEM_WBSEL), .MEM_FUNCT3(MEM_FUNCT3),
        .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_PC4(MEM_PC4),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_BUSY(DMEM_BUSY),
`ifdef WB_FWD_EN
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT),
`endif
        .WB_DATA(WB_DATA), .WB_RD(WB_RD), .WB_WRITE(WB_WRITE),
        .WB_HIT(WB_HIT), .WB_BUSY(WB_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] a,
                                               input logic [2:0] f3);
        logic [7:0] bytes [4];
        int         sel;
        for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
        case (f3)
            3'b000: return 32'($signed(bytes[a]));
            3'b100: return 32'(bytes[a]);
            3'b001: begin sel = a & 2; return 32'($signed({bytes[sel+1], bytes[sel]})); end
            3'b101: begin sel = a & 2; return 32'({bytes[sel+1], bytes[sel]}); end
            default: return word;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs applied for it
    task automatic model_step();
        if (RESET) begin
            m_valid = 0; m_rw = 0; m_pending = 0; m_rd = 0; m_data = 0; m_off = 0; m_f3 = 0;
        end else if (FLUSH) begin
            m_valid = 0; m_pending = 0;
        end else if (m_pending) begin
            if (!DMEM_BUSY) begin
                m_data    = load_value(DMEM_RDATA, m_off, m_f3);
                m_pending = 0;
            end
        end else if (!STALL) begin
            m_valid = MEM_VALID; m_rw = MEM_REGWRITE; m_rd = MEM_RD;
            m_off = MEM_ALU_RESULT[1:0]; m_f3 = MEM_FUNCT3;
            if (MEM_VALID && MEM_WBSEL == 2'b01 && DMEM_BUSY) m_pending = 1;
            else if (MEM_WBSEL == 2'b01) m_data = load_value(DMEM_RDATA, MEM_ALU_RESULT[1:0], MEM_FUNCT3);
            else if (MEM_WBSEL == 2'b10) m_data = MEM_PC4;
            else m_data = MEM_ALU_RESULT;
        end
    endtask

    // Compare process: every cycle on the falling edge, while the register file samples
    always @(negedge CLK) begin
        if (chk_en) begin
            bit hit;
            hit = m_valid && !m_pending;
            chk("wb_data",  WB_DATA,  m_data);
            chk("wb_rd",    32'(WB_RD), 32'(m_rd));
            chk("wb_hit",   32'(WB_HIT), 32'(hit));
            chk("wb_write", 32'(WB_WRITE), 32'(hit && m_rw && m_rd != 0));
            chk("wb_busy",  32'(WB_BUSY), 32'(m_pending));
`ifdef WB_FWD_EN
            chk("fwd1", 32'(FWD1_HIT), 32'(hit && m_rw && m_rd != 0 && ID_RS1 == m_rd));
            chk("fwd2", 32'(FWD2_HIT), 32'(hit && m_rw && m_rd != 0 && ID_RS2 == m_rd));
`endif
        end
    end

    task automatic tick();
        @(posedge CLK);
        model_step();
        chk_en = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        RESET = 0; STALL = 0; FLUSH = 0; MEM_VALID = 0; MEM_REGWRITE = 0; DMEM_BUSY = 0;
        MEM_RD = 0; MEM_WBSEL = 0; MEM_FUNCT3 = 0; MEM_ALU_RESULT = 0; MEM_PC4 = 0; DMEM_RDATA = 0;
    endtask

    task automatic op(input logic [4:0] rd, input logic [1:0] wbsel, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] rdata, input logic busy);
        MEM_VALID = 1; MEM_REGWRITE = 1; MEM_RD = rd; MEM_WBSEL = wbsel; MEM_FUNCT3 = f3;
        MEM_ALU_RESULT = alu; MEM_PC4 = 32'h0000_4004; DMEM_RDATA = rdata; DMEM_BUSY = busy;
    endtask

    initial begin
        idle_inputs();
`ifdef WB_FWD_EN
        ID_RS1 = 0; ID_RS2 = 0;
`endif
        RESET = 1; FLUSH = 1; STALL = 1;
        tick(); tick();
        chk("rst_data", WB_DATA, 32'h0);
        chk("rst_ctrl", 32'({WB_RD, WB_WRITE, WB_HIT, WB_BUSY}), 32'h0);
        idle_inputs();

        op(5, 2'b00, 3'b010, 32'h1234, 32'hDEAD_BEEF, 0); tick();
        chk("alu_data", WB_DATA, 32'h1234);
        chk("alu_rd", 32'(WB_RD), 32'd5);
        chk("alu_write", 32'(WB_WRITE), 32'd1);

        STALL = 1; op(6, 2'b10, 3'b000, 32'h9999, 32'h0, 0); tick();
        chk("stall_hold", WB_DATA, 32'h1234);
        STALL = 0;

        op(3, 2'b01, 3'b000, 32'h1002, 32'h0080_0000, 0); tick();
        chk("lb", WB_DATA, 32'hFFFF_FF80);
        op(3, 2'b01, 3'b101, 32'h1002, 32'h8001_0000, 0); tick();
        chk("lhu", WB_DATA, 32'h0000_8001);
        op(4, 2'b10, 3'b000, 32'h0, 32'h0, 0); tick();
        chk("pc4", WB_DATA, 32'h0000_4004);

        op(0, 2'b00, 3'b000, 32'h55, 32'h0, 0); tick();
        chk("x0_hit", 32'(WB_HIT), 32'd1);
        chk("x0_write", 32'(WB_WRITE), 32'd0);

        op(9, 2'b01, 3'b010, 32'h100, 32'h0, 1); tick();
        MEM_VALID = 0; MEM_WBSEL = 2'b00; MEM_ALU_RESULT = 32'h7777; STALL = 1;
        for (int i = 0; i < 2; i++) begin
            chk("busy_wait", 32'({WB_BUSY, WB_WRITE}), 32'b10);
            tick();
        end
        chk("busy_wait", 32'({WB_BUSY, WB_WRITE}), 32'b10);
        DMEM_BUSY = 0; DMEM_RDATA = 32'hCAFE_F00D; tick();
        chk("busy_done", WB_DATA, 32'hCAFE_F00D);
        chk("busy_write", 32'({WB_BUSY, WB_WRITE, WB_RD}), {25'd0, 2'b01, 5'd9});
        STALL = 0; tick();
        chk("busy_once", 32'(WB_WRITE), 32'd0);

        op(8, 2'b00, 3'b000, 32'h42, 32'h0, 0); tick();
        FLUSH = 1; STALL = 1; tick();
        chk("flush_stall", 32'(WB_HIT), 32'd0);
        FLUSH = 0; STALL = 0;

        op(10, 2'b01, 3'b010, 32'h200, 32'h0, 1); tick();
        FLUSH = 1; tick();
        chk("flush_wait", 32'({WB_BUSY, WB_HIT}), 32'd0);
        FLUSH = 0;

        op(7, 2'b00, 3'b000, 32'hABCD, 32'h0, 0);
`ifdef WB_FWD_EN
        ID_RS1 = 7;
`endif
        tick();
`ifdef WB_FWD_EN
        chk("fwd1_hit", 32'(FWD1_HIT), 32'd1);
        ID_RS1 = 0;
`endif
        op(11, 2'b01, 3'b010, 32'h300, 32'h0, 1); tick();
        chk("wait_entered", 32'(WB_BUSY), 32'd1);
        RESET = 1; tick();
        chk("rst_wait", 32'({WB_DATA, WB_RD, WB_WRITE, WB_HIT, WB_BUSY} != 0), 32'd0);
        idle_inputs();

        for (int n = 0; n < 3000; n++) begin
            RESET = ($urandom_range(99) < 2);
            FLUSH = ($urandom_range(99) < 8);
            STALL = ($urandom_range(99) < 15);
            DMEM_BUSY = ($urandom_range(99) < 40);
            MEM_VALID = ($urandom_range(99) < 80);
            MEM_REGWRITE = ($urandom_range(99) < 80);
            MEM_RD = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom);
            MEM_WBSEL = 2'($urandom);
            MEM_FUNCT3 = 3'($urandom);
            MEM_ALU_RESULT = $urandom;
            MEM_PC4 = $urandom;
            DMEM_RDATA = $urandom;
`ifdef WB_FWD_EN
            ID_RS1 = 5'($urandom); ID_RS2 = m_rd;
`endif
            tick();
        end

        @(negedge CLK);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
